// File: rtl/mult_result_fifo.sv
// In-order result buffer between the multiplier datapath and the output pins: products are visible on out_data the cycle after capture.
// Sustains one push and one pop per cycle. A product that arrives while the buffer is full and not draining is dropped, which sets the sticky overflow flag.
module mult_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic [WIDTH-1:0]           mp_in,
    input  logic                       mp_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    input  logic                       ovf_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             ovf_q;
    logic             push;
    logic             pop;
    logic             drop;

    // Status comes only from registered state, so nothing on the input side reaches an output combinationally.
    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign out_valid = !empty;
    assign out_data  = mem[rd_ptr];
    assign count     = count_q;
    assign overflow  = ovf_q;

    assign pop  = out_valid && out_ready;
    assign push = mp_valid && (!full || pop);
    assign drop = mp_valid && full && !pop;

    // Storage is deliberately left without reset; the pointers alone define what is valid.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= mp_in;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mult_result_fifo.sv
// Directed bench for mult_result_fifo: fixed vectors with hand-computed expectations.
module tb_mult_result_fifo;
    logic       sys_clk;
    logic       sys_rst;
    logic [7:0] mp_in;
    logic       mp_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       ovf_clr;

    int vectors;
    int miscompares;

    mult_result_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .mp_in     (mp_in),
        .mp_valid  (mp_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_one(input logic [7:0] v);
        mp_valid = 1'b1;
        mp_in    = v;
        step();
        mp_valid = 1'b0;
    endtask

    logic [7:0] exp2 [4];
    logic [7:0] exp3 [4];

    initial begin
        vectors     = 0;
        miscompares = 0;
        sys_rst     = 1'b1;
        mp_in       = '0;
        mp_valid    = 1'b0;
        out_ready   = 1'b0;
        ovf_clr     = 1'b0;
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);

        // Single push held, then popped
        sys_rst = 1'b0;
        push_one(8'h8F);
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_data", out_data, 8'h8F);
        chk("t1_count", count, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t1_hold_data", out_data, 8'h8F);
            chk("t1_hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t1_empty", empty, 1);
        chk("t1_count0", count, 0);
        // Popping an empty queue has no effect
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t1_empty_pop_count", count, 0);

        // Fill, overflow drop, drain in order
        exp2 = '{8'h01, 8'h04, 8'h09, 8'h10};
        for (int i = 0; i < 4; i++) push_one(exp2[i]);
        chk("t2_full", full, 1);
        chk("t2_count", count, 4);
        chk("t2_ovf_before", overflow, 0);
        push_one(8'hE1);
        chk("t2_overflow", overflow, 1);
        chk("t2_count_after_drop", count, 4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_drain_data", out_data, exp2[i]);
            step();
        end
        out_ready = 1'b0;
        chk("t2_drained_empty", empty, 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("t2_ovf_cleared", overflow, 0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 4; i++) push_one(8'hA0 + 8'(i));
        mp_valid  = 1'b1;
        mp_in     = 8'h31;
        out_ready = 1'b1;
        step();
        mp_valid  = 1'b0;
        chk("t3_count", count, 4);
        chk("t3_overflow", overflow, 0);
        exp3 = '{8'hA1, 8'hA2, 8'hA3, 8'h31};
        for (int i = 0; i < 4; i++) begin
            chk("t3_drain_data", out_data, exp3[i]);
            step();
        end
        out_ready = 1'b0;
        chk("t3_empty", empty, 1);

        // Pointer wrap with occupancy held at 3
        push_one(8'h00);
        push_one(8'h01);
        push_one(8'h02);
        for (int i = 3; i < 10; i++) begin
            chk("t4_data", out_data, 32'(i - 3));
            mp_valid  = 1'b1;
            mp_in     = 8'(i);
            out_ready = 1'b1;
            step();
            chk("t4_count", count, 3);
        end
        mp_valid = 1'b0;
        for (int i = 7; i < 10; i++) begin
            chk("t4_tail_data", out_data, 32'(i));
            step();
        end
        out_ready = 1'b0;
        chk("t4_empty", empty, 1);

        // Drop and clear in the same cycle: set wins
        for (int i = 0; i < 4; i++) push_one(8'hB0 + 8'(i));
        mp_valid = 1'b1;
        mp_in    = 8'hE2;
        ovf_clr  = 1'b1;
        step();
        mp_valid = 1'b0;
        chk("t5_set_wins", overflow, 1);
        chk("t5_count", count, 4);
        chk("t5_head", out_data, 8'hB0);
        step();
        ovf_clr = 1'b0;
        chk("t5_clr_alone", overflow, 0);

        // Asynchronous reset mid-cycle with three entries queued
        push_one(8'hE3);
        chk("t6_ovf_set", overflow, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t6_count3", count, 3);
        #3;
        sys_rst = 1'b1;
        #1;
        chk("t6_async_count", count, 0);
        chk("t6_async_empty", empty, 1);
        chk("t6_async_valid", out_valid, 0);
        chk("t6_async_full", full, 0);
        chk("t6_async_ovf", overflow, 0);
        #2;
        sys_rst = 1'b0;
        push_one(8'h24);
        chk("t6_first_data", out_data, 8'h24);
        chk("t6_first_count", count, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t6_final_empty", empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
